micro_sequencer: RTL and testbench

- Parametrised next-address sequencer for the microprogrammed control unit. It replaces the combinational next-address mux with a registered micro-PC and a return-address stack.
- Selects among increment, conditional/unconditional branch, register-indirect jump, call and return, using the branch-select code and the PS/Z condition pair.
- Drives the control-memory address each cycle.
- Sits between the control-word decode (bs, ps, bra fields) and the control memory; raa comes from the register file.

---
 rtl/micro_sequencer.sv | 132 +++++++++++++
 tb/tb_micro_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Purpose: registered micro-PC next-address sequencer with a LIFO return-address stack.
// Latency: new pc is visible one cycle after bs/ps/z/bra/raa are sampled; no comb path from bs to pc.
// Backpressure: en=0 freezes pc, stack, depth and sticky flags; reset still acts.
module micro_sequencer #(
  parameter int            AW         = 8,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 bs,
  input  logic                       ps,
  input  logic                       z,
  input  logic [AW-1:0]              bra,
  input  logic [AW-1:0]              raa,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  localparam logic [2:0] OP_INC   = 3'b000;
  localparam logic [2:0] OP_BCOND = 3'b001;
  localparam logic [2:0] OP_JREG  = 3'b010;
  localparam logic [2:0] OP_JMP   = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_CALLC = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] r_stack [DEPTH];

  logic          w_take;
  logic [AW-1:0] w_inc;
  logic          w_full;
  logic          w_empty;
  logic [PW-1:0] w_push_idx;
  logic [PW-1:0] w_pop_idx;
  logic [AW-1:0] w_pc_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_set_ovf;
  logic          w_set_unf;

  assign w_take     = ps ^ z;
  assign w_inc      = r_pc + AW'(1);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  // Low bits only: when full (depth == DEPTH) they wrap to 0 and minus one gives DEPTH-1.
  assign w_push_idx = r_depth[PW-1:0];
  assign w_pop_idx  = r_depth[PW-1:0] - PW'(1);

  // Decode the branch-select code into next pc and stack push/pop/flag requests.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (bs)
      OP_INC:   w_pc_nxt = w_inc;
      OP_BCOND: w_pc_nxt = w_take ? bra : w_inc;
      OP_JREG:  w_pc_nxt = raa;
      OP_JMP:   w_pc_nxt = bra;
      OP_CALL, OP_CALLC: begin
        // CALL is unconditional; CALLC only when taken. A suppressed call falls through.
        if (!bs[0] || w_take) begin
          if (w_full) begin
            w_pc_nxt  = w_inc;
            w_set_ovf = 1'b1;
          end else begin
            w_pc_nxt = bra;
            w_push   = 1'b1;
          end
        end else begin
          w_pc_nxt = w_inc;
        end
      end
      OP_RET: begin
        if (w_empty) begin
          w_pc_nxt  = w_inc;
          w_set_unf = 1'b1;
        end else begin
          w_pc_nxt = r_stack[w_pop_idx];
          w_pop    = 1'b1;
        end
      end
      default: w_pc_nxt = r_pc;
    endcase
  end

  // Micro-PC, stack depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_ADDR;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_pc <= w_pc_nxt;
      if (w_push)
        r_depth <= r_depth + DW'(1);
      else if (w_pop)
        r_depth <= r_depth - DW'(1);
      r_ovf <= r_ovf | w_set_ovf;
      r_unf <= r_unf | w_set_unf;
    end
  end

  // Return-address storage; contents are never cleared, depth alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && en && w_push)
      r_stack[w_push_idx] <= w_inc;
  end

  assign pc    = r_pc;
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_micro_sequencer.sv
// Purpose: directed table-driven check of micro_sequencer (AW=8, DEPTH=4).
// Latency: each vector is driven on the falling edge and checked 1 time unit after the rising edge.
// Backpressure: en is exercised directly by the vectors.
module tb_micro_sequencer;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] bs;
  logic       ps;
  logic       z;
  logic [7:0] bra;
  logic [7:0] raa;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] bs;
    logic       ps;
    logic       z;
    logic [7:0] bra;
    logic [7:0] raa;
    logic [7:0] epc;
    logic [2:0] edep;
    logic       eovf;
    logic       eunf;
  } vec_t;

  vec_t tbl[$];

  micro_sequencer #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bs    (bs),
    .ps    (ps),
    .z     (z),
    .bra   (bra),
    .raa   (raa),
    .pc    (pc),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] INC   = 3'b000;
  localparam logic [2:0] BCOND = 3'b001;
  localparam logic [2:0] JREG  = 3'b010;
  localparam logic [2:0] JMP   = 3'b011;
  localparam logic [2:0] CALL  = 3'b100;
  localparam logic [2:0] CALLC = 3'b101;
  localparam logic [2:0] RET   = 3'b110;
  localparam logic [2:0] HOLD  = 3'b111;

  task automatic add(input logic r, input logic e, input logic [2:0] op, input logic p,
                     input logic zz, input logic [7:0] b, input logic [7:0] ra,
                     input logic [7:0] epc, input logic [2:0] edep, input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.en = e; v.bs = op; v.ps = p; v.z = zz; v.bra = b; v.raa = ra;
    v.epc = epc; v.edep = edep; v.eovf = eo; v.eunf = eu;
    tbl.push_back(v);
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] op,
                      input logic p, input logic zz, input logic [7:0] b, input logic [7:0] ra,
                      input logic [7:0] epc, input logic [2:0] edep, input logic eo, input logic eu);
    logic efull;
    logic eempty;
    @(negedge clk);
    reset = r; en = e; bs = op; ps = p; z = zz; bra = b; raa = ra;
    @(posedge clk);
    #1;
    efull  = (edep == 3'd4);
    eempty = (edep == 3'd0);
    n_vec++;
    if (pc !== epc || depth !== edep || full !== efull || empty !== eempty ||
        ovf !== eo || unf !== eu) begin
      n_err++;
      $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b; want pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
               tag, pc, depth, full, empty, ovf, unf, epc, edep, efull, eempty, eo, eu);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; en = 1'b0; bs = INC; ps = 1'b0; z = 1'b0; bra = 8'h00; raa = 8'h00;

    //   rst en  op     ps z  bra    raa    pc     dep ovf unf
    add(1, 0, INC,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);  // reset state
    add(0, 1, INC,   0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    add(0, 1, INC,   0, 0, 8'h00, 8'h00, 8'h02, 0, 0, 0);
    add(0, 1, INC,   0, 0, 8'h00, 8'h00, 8'h03, 0, 0, 0);
    add(0, 1, JREG,  0, 0, 8'h12, 8'hFF, 8'hFF, 0, 0, 0);
    add(0, 1, INC,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);  // wrap
    add(0, 1, JMP,   0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, BCOND, 0, 1, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    add(0, 1, JMP,   0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, BCOND, 0, 0, 8'h40, 8'h00, 8'h11, 0, 0, 0);
    add(0, 1, JMP,   0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, BCOND, 1, 0, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    add(0, 1, JMP,   0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, BCOND, 1, 1, 8'h40, 8'h00, 8'h11, 0, 0, 0);
    add(0, 1, JMP,   0, 0, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    add(0, 1, CALL,  0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0);
    add(0, 1, INC,   0, 0, 8'h00, 8'h00, 8'h21, 1, 0, 0);
    add(0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h06, 0, 0, 0);
    add(0, 1, HOLD,  0, 0, 8'h77, 8'h88, 8'h06, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].en, tbl[i].bs, tbl[i].ps, tbl[i].z,
           tbl[i].bra, tbl[i].raa, tbl[i].epc, tbl[i].edep, tbl[i].eovf, tbl[i].eunf);

    // Nested calls to full depth, suppressed calls, then unwind in reverse order.
    step("nest_jmp0",  0, 1, JMP,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("nest_call1", 0, 1, CALL,  0, 0, 8'h30, 8'h00, 8'h30, 1, 0, 0);
    step("nest_call2", 0, 1, CALL,  0, 0, 8'h50, 8'h00, 8'h50, 2, 0, 0);
    step("nest_call3", 0, 1, CALL,  0, 0, 8'h70, 8'h00, 8'h70, 3, 0, 0);
    step("nest_call4", 0, 1, CALL,  0, 0, 8'h90, 8'h00, 8'h90, 4, 0, 0);
    step("callc_nt_full", 0, 1, CALLC, 0, 0, 8'hA0, 8'h00, 8'h91, 4, 0, 0);
    step("nest_jmp90", 0, 1, JMP,   0, 0, 8'h90, 8'h00, 8'h90, 4, 0, 0);
    step("call_ovf",   0, 1, CALL,  0, 0, 8'hA0, 8'h00, 8'h91, 4, 1, 0);
    step("ret1",       0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h71, 3, 1, 0);
    step("ret2",       0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h51, 2, 1, 0);
    step("ret3",       0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h31, 1, 1, 0);
    step("ret4",       0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);

    // Underflow, enable hold, conditional calls.
    step("jmp08",      0, 1, JMP,   0, 0, 8'h08, 8'h00, 8'h08, 0, 1, 0);
    step("ret_unf",    0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h09, 0, 1, 1);
    step("en0_hold",   0, 0, JMP,   0, 0, 8'h55, 8'h00, 8'h09, 0, 1, 1);
    step("callc_nt",   0, 1, CALLC, 0, 0, 8'h77, 8'h00, 8'h0A, 0, 1, 1);
    step("callc_tk",   0, 1, CALLC, 1, 0, 8'h60, 8'h00, 8'h60, 1, 1, 1);
    step("callc_ret",  0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h0B, 0, 1, 1);

    // Reset mid-sequence with a non-empty stack, asserted while en=0 and bs=CALL.
    step("pre_call1",  0, 1, CALL,  0, 0, 8'h10, 8'h00, 8'h10, 1, 1, 1);
    step("pre_call2",  0, 1, CALL,  0, 0, 8'h33, 8'h00, 8'h33, 2, 1, 1);
    step("mid_reset",  1, 0, CALL,  0, 0, 8'h44, 8'h00, 8'h00, 0, 0, 0);
    step("post_ret",   0, 1, RET,   0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
